// File: rtl/fp_wire.sv
// Shared types and constants for the floating-point rounding stage.
// The init_* constants are the reset values for the pipeline registers.
package fp_wire;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  // Flag vector layout: {NV,DZ,OF,UF,NX}
  localparam logic [4:0] FLG_NV = 5'b10000;
  localparam logic [4:0] FLG_DZ = 5'b01000;
  localparam logic [4:0] FLG_OF = 5'b00100;
  localparam logic [4:0] FLG_UF = 5'b00010;
  localparam logic [4:0] FLG_NX = 5'b00001;

  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan, qnan, dbz, inf, zero, diff, ready;
  } fp_rnd_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_rnd_out_type;

  // Stage 1: rounded exponent and fraction (fraction top-aligned to 52 bits)
  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [51:0] frac;
    logic        dbl;
    logic [2:0]  rm;
    logic        nx, uf;
    logic        snan, qnan, dbz, inf, zero, diff;
  } fp_round_reg_type_1;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_round_reg_type_2;

  localparam fp_round_reg_type_1 init_fp_round_reg_1 = '0;
  localparam fp_round_reg_type_2 init_fp_round_reg_2 = '0;

  // Singles take the top 23 fraction bits and are NaN-boxed.
  function automatic logic [63:0] fp_pack(input logic dbl, input logic s,
                                          input logic [10:0] e, input logic [51:0] f);
    return dbl ? {s, e, f} : {32'hFFFF_FFFF, s, e[7:0], f[51:29]};
  endfunction

endpackage

// File: rtl/fp_round.sv
// Two-stage IEEE rounding back end: stage 1 applies the rounding increment,
// stage 2 resolves overflow and special operands into the packed result.
module fp_round
  import fp_wire::*;
(
  input  logic           clock,
  input  logic           reset,
  input  fp_rnd_in_type  fp_round_i,
  input  logic           clear,
  output fp_rnd_out_type fp_round_o
);

  localparam int STAGES = 2;

  fp_round_reg_type_1 r1, d1;
  fp_round_reg_type_2 r2, d2;
  logic [STAGES:1]    vld_pipe;
  logic               vld_in;

  logic        inc, hid, dbl_in;
  logic [2:0]  rm_n;
  logic [24:0] sum_s;
  logic [53:0] sum_d;
  logic [13:0] expo_r;
  logic [52:0] mant_r;

  logic        unused_bits;
  assign unused_bits = ^{fp_round_i.rema, fp_round_i.mant[53]};

  assign vld_in = fp_round_i.ready;

  always_comb begin
    dbl_in = fp_round_i.fmt != 2'd0;
    rm_n   = (fp_round_i.rm > RMM) ? RNE : fp_round_i.rm;
    case (rm_n)
      RTZ:     inc = 1'b0;
      RDN:     inc = fp_round_i.sig & (|fp_round_i.grs);
      RUP:     inc = ~fp_round_i.sig & (|fp_round_i.grs);
      RMM:     inc = fp_round_i.grs[2];
      default: inc = fp_round_i.grs[2] & ((|fp_round_i.grs[1:0]) | fp_round_i.mant[0]);
    endcase
    sum_s  = {1'b0, fp_round_i.mant[23:0]} + {24'd0, inc};
    sum_d  = {1'b0, fp_round_i.mant[52:0]} + {53'd0, inc};
    expo_r = fp_round_i.expo;
    if (dbl_in) begin
      mant_r = sum_d[53] ? sum_d[53:1] : sum_d[52:0];
      hid    = mant_r[52];
      if (sum_d[53]) expo_r = expo_r + 14'd1;
    end else begin
      mant_r = {29'd0, (sum_s[24] ? sum_s[24:1] : sum_s[23:0])};
      hid    = mant_r[23];
      if (sum_s[24]) expo_r = expo_r + 14'd1;
    end
    // A subnormal that rounds up into the hidden bit becomes the smallest normal
    if (fp_round_i.expo == 14'd0 && hid) expo_r = 14'd1;

    d1      = init_fp_round_reg_1;
    d1.sig  = fp_round_i.sig;
    d1.expo = expo_r;
    d1.frac = dbl_in ? mant_r[51:0] : {mant_r[22:0], 29'd0};
    d1.dbl  = dbl_in;
    d1.rm   = rm_n;
    d1.nx   = |fp_round_i.grs;
    d1.uf   = (fp_round_i.expo == 14'd0) & (|fp_round_i.grs);
    d1.snan = fp_round_i.snan;
    d1.qnan = fp_round_i.qnan;
    d1.dbz  = fp_round_i.dbz;
    d1.inf  = fp_round_i.inf;
    d1.zero = fp_round_i.zero;
    d1.diff = fp_round_i.diff;
  end

  logic [13:0] emax;
  logic        ovf, to_inf, zsig;

  always_comb begin
    d2     = init_fp_round_reg_2;
    emax   = r1.dbl ? 14'd2047 : 14'd255;
    ovf    = r1.expo >= emax;
    to_inf = (r1.rm == RNE) | (r1.rm == RMM) |
             ((r1.rm == RUP) & ~r1.sig) | ((r1.rm == RDN) & r1.sig);
    zsig   = r1.diff ? (r1.rm == RDN) : r1.sig;
    if (r1.snan) begin
      d2.result = fp_pack(r1.dbl, 1'b0, 11'h7FF, {1'b1, 51'd0});
      d2.flags  = FLG_NV;
    end else if (r1.qnan) begin
      d2.result = fp_pack(r1.dbl, 1'b0, 11'h7FF, {1'b1, 51'd0});
    end else if (r1.dbz) begin
      d2.result = fp_pack(r1.dbl, r1.sig, 11'h7FF, 52'd0);
      d2.flags  = FLG_DZ;
    end else if (r1.inf) begin
      d2.result = fp_pack(r1.dbl, r1.sig, 11'h7FF, 52'd0);
    end else if (r1.zero) begin
      d2.result = fp_pack(r1.dbl, zsig, 11'h000, 52'd0);
    end else if (ovf) begin
      d2.result = to_inf ? fp_pack(r1.dbl, r1.sig, 11'h7FF, 52'd0)
                         : fp_pack(r1.dbl, r1.sig, 11'h7FE, {52{1'b1}});
      d2.flags  = FLG_OF | FLG_NX | (r1.uf ? FLG_UF : 5'd0);
    end else begin
      d2.result = fp_pack(r1.dbl, r1.sig, r1.expo[10:0], r1.frac);
      d2.flags  = {3'd0, r1.uf, r1.nx};
    end
    // Keep result/flags at zero whenever the output slot will be invalid
    if (!vld_pipe[1] || clear) d2 = init_fp_round_reg_2;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1       <= init_fp_round_reg_1;
      r2       <= init_fp_round_reg_2;
      vld_pipe <= '0;
    end else begin
      r1       <= d1;
      r2       <= d2;
      vld_pipe <= {vld_pipe[1], vld_in} & {STAGES{~clear}};
    end
  end

  assign fp_round_o = '{result: r2.result, flags: r2.flags, ready: vld_pipe[STAGES]};

endmodule

// File: tb/tb_fp_round.sv
// Bench for fp_round: directed corner vectors plus a randomized stream with
// flushes, checked against an arithmetic model of IEEE rounding.
module tb_fp_round;
  import fp_wire::*;

  localparam int NR = 300;

  logic           clock = 1'b0;
  logic           reset;
  logic           clear;
  fp_rnd_in_type  fin;
  fp_rnd_out_type fout;

  int total = 0;
  int bad   = 0;

  fp_rnd_in_type hin  [NR];
  bit            hclr [NR];

  always #5 clock = ~clock;

  fp_round dut (
    .clock      (clock),
    .reset      (reset),
    .fp_round_i (fin),
    .clear      (clear),
    .fp_round_o (fout)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] er, input logic [4:0] ef, input logic erdy);
    total++;
    assert (fout.result === er && fout.flags === ef && fout.ready === erdy) else begin
      bad++;
      $error("FAIL %s: got result=%h flags=%b ready=%b, want result=%h flags=%b ready=%b",
             tag, fout.result, fout.flags, fout.ready, er, ef, erdy);
    end
  endtask

  function automatic logic [63:0] mk(input bit dbl, input bit s, input longint unsigned e,
                                     input longint unsigned frac);
    if (dbl) return (64'(s) << 63) | (e << 52) | frac;
    return 64'hFFFF_FFFF_0000_0000 | (64'(s) << 31) | (e << 23) | frac;
  endfunction

  // Rounds a (p-bit significand, exponent) pair with plain integer arithmetic.
  function automatic void ref_model(input fp_rnd_in_type x, output logic [63:0] r, output logic [4:0] f);
    bit dbl;
    int p, rm;
    longint unsigned emax, one, m, e;
    bit inc, nx, uf, to_inf, g;
    dbl  = (x.fmt != 2'd0);
    p    = dbl ? 53 : 24;
    emax = dbl ? 64'd2047 : 64'd255;
    rm   = (x.rm > 3'd4) ? 0 : int'(x.rm);
    one  = 64'd1 << p;
    m    = 64'(x.mant) & (one - 64'd1);
    e    = 64'(x.expo);
    g    = x.grs[2];
    r = '0;
    f = '0;
    if (x.snan) begin
      r = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
      f = 5'b10000;
      return;
    end
    if (x.qnan) begin
      r = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
      return;
    end
    if (x.dbz) begin
      r = mk(dbl, x.sig, emax, 64'd0);
      f = 5'b01000;
      return;
    end
    if (x.inf) begin
      r = mk(dbl, x.sig, emax, 64'd0);
      return;
    end
    if (x.zero) begin
      r = mk(dbl, x.diff ? (rm == 2) : x.sig, 64'd0, 64'd0);
      return;
    end
    case (rm)
      0:       inc = g && (x.grs[1:0] != 2'd0 || (m % 2) == 1);
      1:       inc = 1'b0;
      2:       inc = x.sig && x.grs != 3'd0;
      3:       inc = !x.sig && x.grs != 3'd0;
      default: inc = g;
    endcase
    m = m + 64'(inc);
    if (m >= one) begin
      m = m / 2;
      e = e + 64'd1;
    end
    if (x.expo == 14'd0 && m >= one / 2) e = 64'd1;
    nx = (x.grs != 3'd0);
    uf = (x.expo == 14'd0) && nx;
    if (e >= emax) begin
      to_inf = (rm == 0) || (rm == 4) || (rm == 3 && !x.sig) || (rm == 2 && x.sig);
      r = to_inf ? mk(dbl, x.sig, emax, 64'd0) : mk(dbl, x.sig, emax - 64'd1, one / 2 - 64'd1);
      f = {2'b00, 1'b1, uf, 1'b1};
    end else begin
      r = mk(dbl, x.sig, e, m % (one / 2));
      f = {3'b000, uf, nx};
    end
  endfunction

  function automatic fp_rnd_in_type vec(input logic [1:0] fmt, input logic sig, input logic [13:0] expo,
                                        input logic [53:0] mant, input logic [2:0] grs, input logic [2:0] rm);
    fp_rnd_in_type x;
    x       = '0;
    x.fmt   = fmt;
    x.sig   = sig;
    x.expo  = expo;
    x.mant  = mant;
    x.grs   = grs;
    x.rm    = rm;
    x.ready = 1'b1;
    return x;
  endfunction

  function automatic fp_rnd_in_type rnd_in();
    fp_rnd_in_type x;
    int emax;
    x      = '0;
    x.fmt  = 2'($urandom_range(0, 1));
    x.sig  = 1'($urandom_range(0, 1));
    x.rm   = 3'($urandom_range(0, 7));
    x.grs  = 3'($urandom_range(0, 7));
    x.rema = 2'($urandom_range(0, 3));
    x.mant = {22'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) == 0) x.mant = x.mant | 54'h1F_FFFF_FFFF_FFFF;
    emax = (x.fmt != 2'd0) ? 2047 : 255;
    case ($urandom_range(0, 7))
      0:       x.expo = 14'd0;
      1:       x.expo = 14'(emax - 1);
      2:       x.expo = 14'(emax);
      default: x.expo = 14'($urandom_range(0, emax));
    endcase
    x.snan  = ($urandom_range(0, 15) == 0);
    x.qnan  = ($urandom_range(0, 15) == 0);
    x.dbz   = ($urandom_range(0, 15) == 0);
    x.inf   = ($urandom_range(0, 15) == 0);
    x.zero  = ($urandom_range(0, 15) == 0);
    x.diff  = 1'($urandom_range(0, 1));
    x.ready = ($urandom_range(0, 3) != 0);
    return x;
  endfunction

  task automatic run1(input string tag, input fp_rnd_in_type x, input logic [63:0] er, input logic [4:0] ef);
    fin = x;
    tick;
    fin = '0;
    chk({tag, "_lat1"}, 64'd0, 5'd0, 1'b0);
    tick;
    chk(tag, er, ef, 1'b1);
  endtask

  initial begin
    fp_rnd_in_type a, b, c, d, x;
    logic [63:0] er, er2;
    logic [4:0]  ef, ef2;

    reset = 1'b0;
    clear = 1'b0;
    fin   = vec(2'd0, 1'b0, 14'd100, 54'h12345, 3'b100, RNE);
    tick;
    chk("rst0", 64'd0, 5'd0, 1'b0);
    tick;
    chk("rst1", 64'd0, 5'd0, 1'b0);
    reset = 1'b1;
    fin   = '0;
    tick;
    tick;

    run1("carry1p0", vec(2'd0, 1'b0, 14'd126, 54'hFF_FFFF, 3'b100, RNE),
         64'hFFFF_FFFF_3F80_0000, 5'b00001);
    run1("ovf_rtz", vec(2'd1, 1'b0, 14'd2047, 54'h1F_FFFF_FFFF_FFFF, 3'b111, RTZ),
         64'h7FEF_FFFF_FFFF_FFFF, 5'b00101);
    run1("ovf_rne", vec(2'd1, 1'b0, 14'd2046, 54'h1F_FFFF_FFFF_FFFF, 3'b111, RNE),
         64'h7FF0_0000_0000_0000, 5'b00101);
    x = vec(2'd0, 1'b0, 14'd0, 54'd0, 3'b000, RNE);
    x.snan = 1'b1;
    run1("snan_s", x, 64'hFFFF_FFFF_7FC0_0000, 5'b10000);
    x = vec(2'd1, 1'b1, 14'd0, 54'd0, 3'b000, RNE);
    x.qnan = 1'b1;
    run1("qnan_d", x, 64'h7FF8_0000_0000_0000, 5'b00000);
    x = vec(2'd1, 1'b0, 14'd0, 54'd0, 3'b000, RDN);
    x.zero = 1'b1;
    x.diff = 1'b1;
    run1("zero_rdn", x, 64'h8000_0000_0000_0000, 5'b00000);
    x.rm = RNE;
    run1("zero_rne", x, 64'h0000_0000_0000_0000, 5'b00000);
    x = vec(2'd1, 1'b1, 14'd5, 54'd0, 3'b000, RNE);
    x.dbz = 1'b1;
    run1("dbz_d", x, 64'hFFF0_0000_0000_0000, 5'b01000);
    run1("subn_prom", vec(2'd0, 1'b0, 14'd0, 54'h7F_FFFF, 3'b110, RNE),
         64'hFFFF_FFFF_0080_0000, 5'b00011);
    run1("rdn_neg_max", vec(2'd0, 1'b1, 14'd254, 54'hFF_FFFF, 3'b001, RDN),
         64'hFFFF_FFFF_FF80_0000, 5'b00101);

    // back-to-back stream flushed while two operations are in flight
    a = rnd_in(); a.ready = 1'b1;
    b = rnd_in(); b.ready = 1'b1;
    c = rnd_in(); c.ready = 1'b1;
    d = rnd_in(); d.ready = 1'b1;
    fin = a; tick;
    fin = b; tick;
    ref_model(a, er, ef);
    chk("b2b_a", er, ef, 1'b1);
    fin = c; tick;
    ref_model(b, er, ef);
    chk("b2b_b", er, ef, 1'b1);
    fin = d; clear = 1'b1; tick;
    chk("clr_c", 64'd0, 5'd0, 1'b0);
    fin = '0; clear = 1'b0; tick;
    chk("clr_d", 64'd0, 5'd0, 1'b0);
    tick;

    for (int i = 0; i < NR; i++) begin
      hin[i]  = rnd_in();
      hclr[i] = ($urandom_range(0, 9) == 0);
      fin     = hin[i];
      clear   = hclr[i];
      tick;
      if (i > 0 && hin[i-1].ready && !hclr[i-1] && !hclr[i]) begin
        ref_model(hin[i-1], er, ef);
        chk($sformatf("rnd%0d", i), er, ef, 1'b1);
      end else begin
        chk($sformatf("rnd_idle%0d", i), 64'd0, 5'd0, 1'b0);
      end
    end
    clear = 1'b0;
    fin   = '0;
    tick;
    tick;

    // asynchronous reset with one result visible and one operation in flight
    a = rnd_in(); a.ready = 1'b1; a.snan = 1'b1;
    b = rnd_in(); b.ready = 1'b1;
    fin = a; tick;
    fin = b; tick;
    fin = '0;
    ref_model(a, er2, ef2);
    chk("pre_rst", er2, ef2, 1'b1);
    #2 reset = 1'b0;
    #1 chk("async_rst", 64'd0, 5'd0, 1'b0);
    tick;
    reset = 1'b1;
    tick;
    chk("lost_b0", 64'd0, 5'd0, 1'b0);
    tick;
    chk("lost_b1", 64'd0, 5'd0, 1'b0);
    run1("post_rst", vec(2'd0, 1'b0, 14'd0, 54'h7F_FFFF, 3'b110, RNE),
         64'hFFFF_FFFF_0080_0000, 5'b00011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
